// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - md_op encodings seen on the md_op port (4 bits, codes 7..15 reserved)
//   - default busy latencies for multiply and divide
//   - FSM state type and a helper that classifies long-latency ops
package md_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_DIV)  || (op == OP_DIVU);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational arithmetic core of the multiply/divide unit.
// Ports:
//   src_a, src_b  in  32  operands (rs, rt)
//   md_op         in  4   operation select (md_pkg encoding)
//   res_hi        out 32  HI result (product upper half / remainder)
//   res_lo        out 32  LO result (product lower half / quotient)
//   div_zero      out 1   divide op with a zero divisor
module md_arith
  import md_pkg::*;
(
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [3:0]  md_op,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] div_b;
  logic        [31:0] mag_a;
  logic        [31:0] mag_b;
  logic        [31:0] q_mag;
  logic        [31:0] r_mag;
  logic        [31:0] q_u;
  logic        [31:0] r_u;

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // A zero divisor is replaced by 1 so the dividers never see /0; the
  // result is discarded at commit anyway.
  assign div_b = (src_b == 32'd0) ? 32'd1 : src_b;
  assign q_u   = src_a / div_b;
  assign r_u   = src_a % div_b;

  // Signed divide done on magnitudes. 0x80000000 has magnitude 0x80000000
  // as an unsigned value, so the overflow case 0x80000000 / -1 falls out
  // naturally as 0x80000000 with remainder 0.
  assign mag_a = src_a[31] ? (32'd0 - src_a) : src_a;
  assign mag_b = div_b[31] ? (32'd0 - div_b) : div_b;
  assign q_mag = mag_a / mag_b;
  assign r_mag = mag_a % mag_b;

  always_comb begin
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    div_zero = 1'b0;
    case (md_op)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        div_zero = (src_b == 32'd0);
        // Quotient truncates toward zero; remainder follows the dividend.
        res_lo   = (src_a[31] ^ div_b[31]) ? (32'd0 - q_mag) : q_mag;
        res_hi   = src_a[31] ? (32'd0 - r_mag) : r_mag;
      end
      OP_DIVU: begin
        div_zero = (src_b == 32'd0);
        res_lo   = q_u;
        res_hi   = r_u;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO registers for the E stage of the
// pipelined MIPS core. The result is computed on acceptance, held in
// pending registers, and committed to HI/LO after a fixed busy period.
// Ports:
//   clk     in  1   rising-edge clock
//   reset   in  1   asynchronous, active-low reset
//   start   in  1   one-cycle request qualified by md_op
//   md_op   in  4   operation (md_pkg encoding)
//   src_a   in  32  rs operand
//   src_b   in  32  rt operand
//   busy    out 1   operation in flight (registered)
//   hi, lo  out 32  architectural HI/LO registers
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  md_state_e          state;
  md_state_e          state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        p_hi;
  logic [31:0]        p_lo;
  logic               p_dz;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               div_zero;
  logic               accept_arith;
  logic               accept_mthi;
  logic               accept_mtlo;
  logic               commit;

  md_arith u_arith (
    .src_a    (src_a),
    .src_b    (src_b),
    .md_op    (md_op),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  // Requests are only honoured in IDLE; anything arriving during RUN is dropped.
  assign accept_arith = (state == IDLE) && start && is_arith(md_op);
  assign accept_mthi  = (state == IDLE) && start && (md_op == OP_MTHI);
  assign accept_mtlo  = (state == IDLE) && start && (md_op == OP_MTLO);
  assign commit       = (state == RUN) && (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_arith) state_nxt = RUN;
      RUN:     if (commit)       state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      p_hi <= 32'd0;
      p_lo <= 32'd0;
      p_dz <= 1'b0;
      hi   <= 32'd0;
      lo   <= 32'd0;
    end else begin
      if (accept_arith) begin
        cnt  <= is_mul(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        p_hi <= res_hi;
        p_lo <= res_lo;
        p_dz <= div_zero;
      end else if (state == RUN) begin
        cnt <= cnt - CNT_W'(1);
      end

      // A divide by zero still burns its busy cycles but leaves HI/LO alone.
      if (commit && !p_dz) begin
        hi <= p_hi;
        lo <= p_lo;
      end
      if (accept_mthi) hi <= src_a;
      if (accept_mtlo) lo <= src_a;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] eh, input logic [31:0] el, input int cyc);
    exp_t e;
    e.hi  = eh;
    e.lo  = el;
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Called at a negedge; holds start for exactly one cycle.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
    md_op = OP_NONE;
    src_a = 32'd0;
    src_b = 32'd0;
  endtask

  // Returns at the negedge of the first non-busy cycle.
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy) begin
      fails++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
    end
  endtask

  // Monitor: every time busy falls, the committed HI/LO and the busy run
  // length are compared with the oldest scoreboard entry.
  initial begin
    int   run;
    logic prev;
    exp_t e;
    run  = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        run  = 0;
        prev = 1'b0;
      end else begin
        if (busy) begin
          run++;
        end else if (prev) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: result hi=0x%08h lo=0x%08h with empty scoreboard", hi, lo);
          end else begin
            e = sb.pop_front();
            chk("mon_hi", hi, e.hi);
            chk("mon_lo", lo, e.lo);
            chk("mon_busy_len", 32'(run), 32'(e.cyc));
          end
          run = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    md_op = OP_NONE;
    src_a = 32'd0;
    src_b = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_hi", hi, 32'd0);

    // MULT -3 * 5 = -15
    push(32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_idle("mult");

    // MULTU max*max, then MULT 2*3 in the first non-busy cycle
    push(32'hFFFF_FFFE, 32'h0000_0001, 5);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("multu");
    push(32'd0, 32'd6, 5);
    issue(OP_MULT, 32'd2, 32'd3);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_idle("mult_b2b");

    // DIV -7 / 2 = -3 rem -1
    push(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_neg");

    // DIV overflow case
    push(32'd0, 32'h8000_0000, 10);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf");

    // DIVU 7 / 2
    push(32'd1, 32'd3, 10);
    issue(OP_DIVU, 32'd7, 32'd2);
    wait_idle("divu");

    // MTHI: visible one edge later, no busy
    issue(OP_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo_kept", lo, 32'd3);
    chk("mthi_busy", {31'd0, busy}, 32'd0);

    // DIVU by zero: full busy run, HI/LO untouched
    push(32'h1234_5678, 32'd3, 10);
    issue(OP_DIVU, 32'd5, 32'd0);
    wait_idle("divu_zero");

    // MTLO
    issue(OP_MTLO, 32'h0000_0055, 32'd0);
    chk("mtlo_lo", lo, 32'h0000_0055);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    // DIV 100 / 7 = 14 rem 2, with stray starts during RUN
    push(32'd2, 32'd14, 10);
    issue(OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    issue(OP_MULT, 32'd2, 32'd3);
    issue(OP_MTLO, 32'h0000_AAAA, 32'd0);
    chk("run_lo_held", lo, 32'h0000_0055);
    wait_idle("div_ignore");
    tests++;
    if (lo == 32'h0000_AAAA) begin
      fails++;
      $display("FAIL ignore_mtlo: got lo=0x%08h, expected anything but 0x0000aaaa", lo);
    end

    // Asynchronous reset in the middle of cycle 4 of a DIV
    issue(OP_DIV, 32'd9, 32'd2);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);

    // MULT 7 * 6 after reset
    push(32'd0, 32'd42, 5);
    issue(OP_MULT, 32'd7, 32'd6);
    wait_idle("mult_after_rst");

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative-latency multiply/divide unit with HI/LO registers for the five-stage pipelined MIPS core. Sits in the execute stage beside the ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E, and exposes `busy` to the stall controller. It presents HI/LO to the E-stage result mux for MFHI/MFLO.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request, qualified by `md_op`.
- `md_op`  in  4  operation, encoded as listed under Structure.
- `src_a`  in  32  rs operand, already forwarded.
- `src_b`  in  32  rt operand, already forwarded.
- `busy`  out  1  operation in flight.
- `hi`  out  32  HI register, registered.
- `lo`  out  32  LO register, registered.

## Operation
- **States:** IDLE and RUN. A down-counter `cnt` has width covering `max(MULT_CYCLES, DIV_CYCLES)`.
- **IDLE with `start=1` and `md_op` ∈ {MULT, MULTU, DIV, DIVU}:**
  - Latch the arithmetic result into pending registers `p_hi` and `p_lo`.
  - Load `cnt` with the op latency.
  - Go to RUN.
- **RUN:**
  - Decrement `cnt` each cycle.
  - When `cnt==1`, commit `p_hi`→`hi` and `p_lo`→`lo`, then go to IDLE.
- **`busy`:** equals `(state==RUN)`, a registered decode.
- **MTHI/MTLO with `start=1`:**
  - Write `src_a` to `hi`/`lo` at that edge.
  - No busy cycles.
  - Accepted only in IDLE.
- **`start` while RUN:** ignored, whatever `md_op` is. The stall controller prevents this; the block still defines it as a no-op.
- **`start=1` with `md_op` = NONE or an undefined code:** no-op.
- **Arithmetic:**
  - MULT: 64-bit signed product; `{hi, lo}` = product.
  - MULTU: 64-bit unsigned product; `{hi, lo}` = product.
  - DIV: `lo` = signed quotient, truncated toward zero; `hi` = remainder, with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- **Divide boundary cases:**
  - Divisor zero (DIV or DIVU): the full busy sequence still runs, but `hi`/`lo` are NOT updated at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- **Reset:** `reset=0` at any time, including mid-RUN, forces IDLE, `cnt`=0, `busy`=0, `hi`=`lo`=0, `p_hi`=`p_lo`=0. The pending result is discarded.

## Timing
- **Multiply/divide request:** `start` is high in cycle 0.
  - `busy`=1 in cycles 1..N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - New `hi`/`lo` are visible from cycle N+1, which is also the first cycle with `busy`=0.
- **Back-to-back:** a new `start` is accepted in cycle N+1 (no dead cycle).
- **MTHI/MTLO:** `start` in cycle 0 → new value visible in cycle 1. `busy` stays 0.
- **Stall contract:**
  - The stall controller stalls any MD instruction in D while `start` (from E) or `busy` is high.
  - `hi`/`lo` during RUN hold their old values; MFHI/MFLO must not issue then.
- **Outputs from reset release:** all 0 until the first accepted request.
- **Latency:** MUL/DIV is N+1 edges from `start` to result. MT* is 1 edge.

## Structure
- **Shared package `md_pkg`:**
  - `md_op` encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; codes 7–15 are reserved (no-op).
  - Default latency constants 5 and 10.
  - State typedef {IDLE, RUN}.
- **Sub-module `md_arith`:** purely combinational. Takes `src_a`, `src_b`, `md_op`; returns `res_hi`, `res_lo`, `div_zero`.
- **Top level:** FSM, counter, pending registers and HI/LO registers.

## Test plan
- MULT `src_a`=0xFFFFFFFD (−3), `src_b`=5 → `busy`=1 for exactly 5 cycles. Then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001 after 5 busy cycles. Immediately follow with MULT 2×3 in the first non-busy cycle → accepted; `lo`=6, `hi`=0.
- DIV −7/2 → `busy` for 10 cycles. Then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - DIVU 7/2 → `lo`=3, `hi`=1.
- MTHI 0x12345678, then DIVU 5/0 → `busy` for 10 cycles. Afterwards `hi`=0x12345678 (unchanged) and `lo` keeps its prior value.
- During a DIV's RUN, pulse `start` with MULT and with MTLO 0xAAAA → both ignored. The DIV result commits on schedule; `lo` ≠ 0xAAAA.
- Assert `reset=0` asynchronously mid-clock in cycle 4 of a DIV → `busy`, `hi` and `lo` go 0 immediately. After release, no stale commit occurs and the next MULT works normally.
